// File: rtl/narrow_responder.sv
// Narrow-bus responder: byte/halfword transfers as byte accesses on an 8-bit wait-state device.
// Optional MISALIGN_ERR_EN: misaligned halfwords return an error pulse instead of executing.
module narrow_responder #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [63:0]       s_adr_i,
  input  logic              s_cyc_i,
  input  logic              s_stb_i,
  input  logic              s_we_i,
  input  logic              s_siz_i,
  input  logic [15:0]       s_dat_i,
  output logic              s_ack_o,
  output logic [15:0]       s_dat_o,
  output logic              s_err_o,
  output logic [ADDR_W-1:0] dev_adr_o,
  output logic [7:0]        dev_dat_o,
  input  logic [7:0]        dev_dat_i,
  output logic              dev_stb_o,
  output logic              dev_we_o
);

  typedef enum logic [1:0] {
    IDLE,
    BYTE0,
    BYTE1,
    ACK
  } state_t;

  localparam int CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_STATES);

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ADDR_W-1:0] adr, adr_n;
  logic              we, we_n;
  logic              siz, siz_n;
  logic [15:0]       dat, dat_n;
  logic [15:0]       rdata, rdata_n;
  logic              hold, hold_n;
  logic              mis, mis_n;
  logic              last;
  logic              unused_adr;

  // Upper address bits beyond ADDR_W are deliberately ignored.
  assign unused_adr = ^s_adr_i;

  assign last = (cnt == LAST);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state <= IDLE;
      cnt   <= '0;
      adr   <= '0;
      we    <= 1'b0;
      siz   <= 1'b0;
      dat   <= '0;
      rdata <= '0;
      hold  <= 1'b0;
      mis   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      adr   <= adr_n;
      we    <= we_n;
      siz   <= siz_n;
      dat   <= dat_n;
      rdata <= rdata_n;
      hold  <= hold_n;
      mis   <= mis_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    adr_n   = adr;
    we_n    = we;
    siz_n   = siz;
    dat_n   = dat;
    rdata_n = rdata;
    hold_n  = 1'b0;
    mis_n   = mis;
    unique case (state)
      IDLE: begin
        // hold masks the cycle right after ACK so a stale stb is not re-taken
        if (!hold && s_cyc_i && s_stb_i) begin
          adr_n   = s_adr_i[ADDR_W-1:0];
          we_n    = s_we_i;
          siz_n   = s_siz_i;
          dat_n   = s_dat_i;
          cnt_n   = '0;
          mis_n   = 1'b0;
          state_n = BYTE0;
`ifdef MISALIGN_ERR_EN
          if (s_siz_i && s_adr_i[0]) begin
            mis_n   = 1'b1;
            state_n = ACK;
          end
`endif
        end
      end
      BYTE0: begin
        if (!s_cyc_i) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (last) begin
          cnt_n = '0;
          if (!we) begin
            if (siz) rdata_n = {rdata[15:8], dev_dat_i};
            else     rdata_n = {8'h00, dev_dat_i};
          end
          state_n = siz ? BYTE1 : ACK;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BYTE1: begin
        if (!s_cyc_i) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (last) begin
          cnt_n = '0;
          if (!we) rdata_n = {dev_dat_i, rdata[7:0]};
          state_n = ACK;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ACK: begin
        hold_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign dev_stb_o = (state == BYTE0) || (state == BYTE1);
  assign dev_we_o  = dev_stb_o && we;
  assign s_ack_o   = (state == ACK) && !mis;
  assign s_dat_o   = rdata;

  always_comb begin
    dev_adr_o = '0;
    dev_dat_o = '0;
    unique case (1'b1)
      (state == BYTE0): begin
        dev_adr_o = adr;
        dev_dat_o = dat[7:0];
      end
      (state == BYTE1): begin
        dev_adr_o = adr + ADDR_W'(1);
        dev_dat_o = dat[15:8];
      end
      default: begin
        dev_adr_o = '0;
        dev_dat_o = '0;
      end
    endcase
  end

`ifdef MISALIGN_ERR_EN
  logic err;

  // Registered so the error lands two cycles after acceptance.
  always_ff @(posedge clk_i) begin
    if (!reset_i) err <= 1'b0;
    else          err <= (state == ACK) && mis;
  end

  assign s_err_o = err;
`else
  assign s_err_o = 1'b0;
`endif

endmodule

// File: doc/narrow_responder.md
Name: narrow_responder

Overview:
- Responder (slave end) of the 16-bit narrow bus that the bus narrowing bridge drives as initiator.
- Accepts byte or halfword transfers and executes them as one or two byte accesses on an 8-bit, fixed-wait-state device port.
- Returns read data and a single-cycle acknowledge to the narrow bus.

Parameters:
WAIT_STATES, 2, extra cycles dev_stb_o is held per byte access (each byte access lasts WAIT_STATES+1 cycles)
ADDR_W, 16, device address width; s_adr_i bits above ADDR_W-1 are ignored

Ports:
clk_i  in  1  clock; all logic on rising edge
reset_i  in  1  synchronous, active-low reset
s_adr_i  in  64  transfer byte address
s_cyc_i  in  1  bus cycle in progress
s_stb_i  in  1  transfer request
s_we_i  in  1  1=write, 0=read
s_siz_i  in  1  0=byte, 1=halfword
s_dat_i  in  16  write data, little-endian
s_ack_o  out  1  transfer complete, one-cycle pulse
s_dat_o  out  16  read data, registered
s_err_o  out  1  error pulse (MISALIGN_ERR_EN only, else tied 0)
dev_adr_o  out  ADDR_W  device byte address
dev_dat_o  out  8  device write data
dev_dat_i  in  8  device read data
dev_stb_o  out  1  device access strobe
dev_we_o  out  1  device write enable

Behaviour:
- Reset (reset_i=0 at clock edge): state IDLE; s_ack_o, s_err_o, s_dat_o, dev_stb_o, dev_we_o, dev_adr_o and dev_dat_o all 0. Reset overrides any state, including mid-transfer: no ack and no further device access follow.
- States: IDLE, BYTE0, BYTE1, ACK. A wait counter of width clog2(WAIT_STATES+1) runs in the BYTE states.
- IDLE:
  - If s_cyc_i & s_stb_i, latch adr[ADDR_W-1:0], we, siz and dat_i; go to BYTE0.
  - The acceptance cycle does not assert dev_stb_o.
- BYTE0:
  - dev_stb_o=1, dev_adr_o=latched adr, dev_we_o=latched we, dev_dat_o=dat[7:0].
  - Hold for WAIT_STATES+1 cycles. On the last cycle, a read captures dev_dat_i into s_dat_o[7:0].
  - Next state is BYTE1 if siz=1, else ACK.
- BYTE1:
  - dev_adr_o=adr+1, computed modulo 2^ADDR_W (0xFFFF wraps to 0x0000); dev_dat_o=dat[15:8].
  - Hold for WAIT_STATES+1 cycles. On the last cycle, a read captures dev_dat_i into s_dat_o[15:8]. Then go to ACK.
  - dev_stb_o stays high across the BYTE0->BYTE1 boundary.
- ACK:
  - dev_stb_o=0 and s_ack_o=1 for exactly one cycle; return to IDLE.
  - IDLE ignores s_stb_i for that one cycle, so the master drops or updates stb after sampling ack. Next acceptance is no earlier than ACK+2.
- Byte read: s_dat_o[15:8] is cleared to 0 at capture.
- s_dat_o holds its value until the next read capture. Writes do not change s_dat_o.
- Latency from acceptance cycle T: byte ack at T+2+WAIT_STATES; halfword ack at T+3+2*WAIT_STATES.
- s_cyc_i low in BYTE0/BYTE1 (abort):
  - Next cycle: state IDLE, dev_stb_o=0, no ack.
  - A device write byte already strobed stays committed.
  - s_dat_o keeps bytes already captured.
- s_stb_i changes after acceptance are ignored until ACK.
- s_we_i, s_siz_i and s_dat_i are sampled only at acceptance.

Optional Feature:
MISALIGN_ERR_EN
- Defined: a halfword request with adr[0]=1 is not executed. The block goes IDLE -> ACK, pulses s_err_o=1 (s_ack_o stays 0) for one cycle two cycles after acceptance, performs no device access and leaves s_dat_o unchanged.
- Undefined: misaligned halfwords execute normally (bytes at adr and adr+1) and s_err_o is constant 0.

Test Plan:
- Reset mid-halfword-write (WAIT_STATES=2): drop reset_i during BYTE0 -> next cycle dev_stb_o=0, s_ack_o=0, all outputs 0, no BYTE1 access.
- Byte read adr=0x0000_0000_0000_1234, device returns 0xA5 -> dev_adr_o=0x1234 with stb high 3 cycles, s_ack_o at T+4, s_dat_o=0x00A5.
- Halfword write adr=0x2000, s_dat_i=0xBEEF -> dev writes 0xEF@0x2000 then 0xBE@0x2001, dev_stb_o high 6 cycles continuously, ack at T+7.
- Halfword read adr=0xFFFF (no MISALIGN_ERR_EN), device returns 0x11 then 0x22 -> second access at 0x0000, s_dat_o=0x2211.
- Abort: halfword read, s_cyc_i low on first BYTE1 cycle -> IDLE next cycle, no ack, s_dat_o[7:0] holds the captured byte.
- MISALIGN_ERR_EN defined: halfword at adr=0x0003 -> s_err_o pulse at T+2, s_ack_o=0, dev_stb_o never asserted.
